// File: rtl/up_down_count_decoder.sv
// -----------------------------------------------------------------------------
// up_down_count_decoder
//
// Purpose:
//   Receive-side companion to up_down_counter. Samples the observed count bus,
//   classifies each step as HOLD / UP (+1) / DOWN (-1) / ERR (anything else,
//   modulo 2**WIDTH), flags wrap events and illegal steps, and keeps a
//   saturating tally of illegal steps. The first sample after reset only
//   acquires a reference value, so a post-reset jump is never an error.
//
// Optional feature:
//   STALL_DETECT_EN - when defined, counts consecutive HOLD samples and raises
//                     'stalled' once STALL_LIMIT of them have been seen. When
//                     undefined, 'stalled' is tied to 0.
//
// Parameters:
//   WIDTH        width of the observed count bus
//   ERR_CNT_W    width of the saturating illegal-step counter
//   STALL_LIMIT  consecutive HOLD samples before 'stalled' asserts
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   count_in   in   observed counter value
//   sample_en  in   1 = sample count_in this cycle, 0 = freeze all state
//   dir_up     out  level: last classified step was +1
//   dir_down   out  level: last classified step was -1
//   wrap_up    out  1-cycle pulse: step max -> 0
//   wrap_down  out  1-cycle pulse: step 0 -> max
//   step_err   out  1-cycle pulse: illegal step detected
//   err_cnt    out  saturating count of illegal steps
//   state      out  FSM state encoding (debug)
//   stalled    out  level: count held for >= STALL_LIMIT samples
// -----------------------------------------------------------------------------
module up_down_count_decoder #(
    parameter int WIDTH       = 4,
    parameter int ERR_CNT_W   = 8,
    parameter int STALL_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 sample_en,
    output logic                 dir_up,
    output logic                 dir_down,
    output logic                 wrap_up,
    output logic                 wrap_down,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           state,
    output logic                 stalled
);

    typedef enum logic [2:0] {
        ST_ACQ  = 3'd0,
        ST_HOLD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   dir_up_q, dir_up_d;
    logic                   dir_down_q, dir_down_d;
    logic                   wrap_up_q, wrap_up_d;
    logic                   wrap_down_q, wrap_down_d;
    logic                   step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]       delta;
    logic                   classify;

    // Modulo-2**WIDTH difference: wrap steps fall out as +1 / -1 naturally.
    assign delta = count_in - prev_q;

    // A sample is classified only once a reference value has been acquired
    // and the FSM sits in one of the legal post-acquisition states.
    assign classify = sample_en && prev_valid_q &&
                      (state_q inside {ST_HOLD, ST_UP, ST_DOWN, ST_ERR});

    // -------------------------------------------------------------------------
    // Next-state / output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        dir_up_d     = dir_up_q;
        dir_down_d   = dir_down_q;
        err_cnt_d    = err_cnt_q;
        wrap_up_d    = 1'b0;
        wrap_down_d  = 1'b0;
        step_err_d   = 1'b0;

        if (!(state_q inside {ST_ACQ, ST_HOLD, ST_UP, ST_DOWN, ST_ERR})) begin
            // Unreachable encodings recover to ACQ even while frozen, so a
            // corrupted state cannot persist behind a deasserted sample_en.
            state_d      = ST_ACQ;
            prev_valid_d = 1'b0;
        end else if (sample_en && !classify) begin
            // Acquisition: take a reference value only, no classification.
            prev_d       = count_in;
            prev_valid_d = 1'b1;
            state_d      = ST_HOLD;
        end else if (classify) begin
            prev_d = count_in;
            if (delta == '0) begin
                state_d    = ST_HOLD;
                dir_up_d   = 1'b0;
                dir_down_d = 1'b0;
            end else if (delta == CNT_ONE) begin
                state_d    = ST_UP;
                dir_up_d   = 1'b1;
                dir_down_d = 1'b0;
                wrap_up_d  = (prev_q == CNT_MAX);
            end else if (delta == CNT_MAX) begin
                state_d     = ST_DOWN;
                dir_up_d    = 1'b0;
                dir_down_d  = 1'b1;
                wrap_down_d = (prev_q == '0);
            end else begin
                state_d    = ST_ERR;
                dir_up_d   = 1'b0;
                dir_down_d = 1'b0;
                step_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ACQ;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            dir_up_q     <= 1'b0;
            dir_down_q   <= 1'b0;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            dir_up_q     <= dir_up_d;
            dir_down_q   <= dir_down_d;
            wrap_up_q    <= wrap_up_d;
            wrap_down_q  <= wrap_down_d;
            step_err_q   <= step_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional stall detection
    // -------------------------------------------------------------------------
`ifdef STALL_DETECT_EN
    localparam int              HR_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [HR_W-1:0] HR_LIMIT = HR_W'(STALL_LIMIT);

    logic [HR_W-1:0] hold_run_q, hold_run_d;
    logic            stalled_q, stalled_d;

    always_comb begin
        hold_run_d = hold_run_q;
        if (classify) begin
            if (state_d == ST_HOLD) begin
                if (hold_run_q != HR_LIMIT) begin
                    hold_run_d = hold_run_q + HR_W'(1);
                end
            end else begin
                hold_run_d = '0;
            end
        end
        stalled_d = (hold_run_d == HR_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_run_q <= '0;
            stalled_q  <= 1'b0;
        end else begin
            hold_run_q <= hold_run_d;
            stalled_q  <= stalled_d;
        end
    end

    assign stalled = stalled_q;
`else
    assign stalled = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state     = state_q;
    assign dir_up    = dir_up_q;
    assign dir_down  = dir_down_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign step_err  = step_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_up_down_count_decoder.sv
// -----------------------------------------------------------------------------
// tb_up_down_count_decoder
//
// Directed stimulus for up_down_count_decoder. The stimulus process drives one
// sample per clock (at the falling edge) and pushes the hand-derived expected
// outputs into a queue; an independent monitor pops and compares one entry
// after each rising edge. Reset behaviour is checked directly while reset is
// held.
// -----------------------------------------------------------------------------
module tb_up_down_count_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       sample_en;
    logic       dir_up, dir_down, wrap_up, wrap_down, step_err, stalled;
    logic [7:0] err_cnt;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       up;
        logic       dn;
        logic       wu;
        logic       wd;
        logic       se;
        logic [7:0] ec;
        logic       stl;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   next_tag = 0;
    int   total    = 0;
    int   bad      = 0;
    bit   stall_en;
    exp_t act;

    up_down_count_decoder #(
        .WIDTH       (4),
        .ERR_CNT_W   (8),
        .STALL_LIMIT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .sample_en (sample_en),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .step_err  (step_err),
        .err_cnt   (err_cnt),
        .state     (state),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    assign act = {state, dir_up, dir_down, wrap_up, wrap_down, step_err, err_cnt, stalled};

    function automatic exp_t mk(int st, bit up, bit dn, bit wu, bit wd, bit se, int ec, bit stl);
        exp_t e;
        e.st  = st[2:0];
        e.up  = up;
        e.dn  = dn;
        e.wu  = wu;
        e.wd  = wd;
        e.se  = se;
        e.ec  = ec[7:0];
        e.stl = stl;
        return e;
    endfunction

    task automatic check(input string name, input int tag, input exp_t a, input exp_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s #%0d: got st=%0d up=%b dn=%b wu=%b wd=%b se=%b ec=%0d stl=%b, want st=%0d up=%b dn=%b wu=%b wd=%b se=%b ec=%0d stl=%b",
                     name, tag, a.st, a.up, a.dn, a.wu, a.wd, a.se, a.ec, a.stl,
                     e.st, e.up, e.dn, e.wu, e.wd, e.se, e.ec, e.stl);
        end
    endtask

    // Monitor: one expected entry per rising edge while out of reset.
    initial begin
        exp_t e;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check("sample", t, act, e);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input int cnt, input bit en, input exp_t e);
        count_in  = cnt[3:0];
        sample_en = en;
        exp_q.push_back(e);
        tag_q.push_back(next_tag);
        next_tag++;
        @(negedge clk);
    endtask

    // Bounded wait for the monitor to consume all pending expectations.
    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release at a falling edge.
    task automatic apply_reset();
        sample_en = 1'b0;
        drain();
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", next_tag, act, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef STALL_DETECT_EN
        stall_en = 1'b1;
`else
        stall_en = 1'b0;
`endif
        reset     = 1'b1;
        sample_en = 1'b0;
        count_in  = '0;
        #8;
        check("reset_init", 0, act, '0);
        @(negedge clk);
        reset = 1'b0;

        // 1: count up from 0, acquire first, wrap 15->0 at the end
        drive(0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 16; i++)
            drive(i % 16, 1'b1, mk(2, 1, 0, i == 16, 0, 0, 0, 0));

        // 2: count down from 0, wrap 0->15 on the first step
        for (int i = 0; i < 16; i++)
            drive(15 - i, 1'b1, mk(3, 0, 1, 0, i == 0, 0, 0, 0));

        // 3: illegal 3->7, recovery 7->8, then 300 steps of +2 to saturate
        for (int v = 1; v <= 3; v++)
            drive(v, 1'b1, mk(2, 1, 0, 0, 0, 0, 0, 0));
        drive(7, 1'b1, mk(4, 0, 0, 0, 0, 1, 1, 0));
        drive(8, 1'b1, mk(2, 1, 0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= 300; k++)
            drive((8 + 2 * k) % 16, 1'b1, mk(4, 0, 0, 0, 0, 1, (k + 1 > 255) ? 255 : k + 1, 0));

        // 4: build err_cnt=5 in state UP, then reset mid-operation
        apply_reset();
        drive(0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 5; k++)
            drive(2 * k, 1'b1, mk(4, 0, 0, 0, 0, 1, k, 0));
        drive(11, 1'b1, mk(2, 1, 0, 0, 0, 0, 5, 0));
        apply_reset();
        drive(9, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0));

        // 5: step down to 2, freeze while count moves, re-enable at 7
        for (int v = 8; v >= 2; v--)
            drive(v, 1'b1, mk(3, 0, 1, 0, 0, 0, 0, 0));
        for (int v = 3; v <= 6; v++)
            drive(v, 1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0));
        drive(7, 1'b1, mk(4, 0, 0, 0, 0, 1, 1, 0));
        drive(7, 1'b0, mk(4, 0, 0, 0, 0, 0, 1, 0));

        // 6: hold at 5 for eight samples, then step to 6
        drive(5, 1'b1, mk(4, 0, 0, 0, 0, 1, 2, 0));
        for (int k = 1; k <= 8; k++)
            drive(5, 1'b1, mk(1, 0, 0, 0, 0, 0, 2, stall_en && (k == 8)));
        drive(6, 1'b1, mk(2, 1, 0, 0, 0, 0, 2, 0));

        sample_en = 1'b0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
